// File: rtl/lock_pkg.sv
// Shared types and helpers for the combination lock.
// Symbol i of a packed code lives at bits [i*sym_w +: sym_w].
package lock_pkg;

   typedef enum logic [1:0] {
      LOCKED,
      ENTRY,
      OPEN,
      LOCKOUT
   } lock_state_e;

   localparam int unsigned MAX_CODE_W = 64;
   localparam int unsigned MAX_SYM_W  = 16;

   function automatic logic [MAX_SYM_W-1:0] sym_at(input logic [MAX_CODE_W-1:0] code,
                                                  input int unsigned           idx,
                                                  input int unsigned           sym_w);
      logic [MAX_CODE_W-1:0] mask;
      mask = ~({MAX_CODE_W{1'b1}} << sym_w);
      return MAX_SYM_W'((code >> (idx * sym_w)) & mask);
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; expired flags the final cycle of a loaded interval.
// A load of N makes expired high during the N-th cycle after the load.
module lock_timer #(
   parameter int unsigned W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == W'(1));

endmodule

// File: rtl/combo_lock.sv
// Symbol-sequence combination lock with failed-attempt lockout and entry timeout.
// All outputs are registered; the timer is shared between entry timeout and lockout.
module combo_lock
   import lock_pkg::*;
#(
   parameter int unsigned                 SYM_W       = 2,
   parameter int unsigned                 CODE_LEN    = 4,
   parameter logic [CODE_LEN*SYM_W-1:0]   RESET_CODE  = 8'h27,
   parameter int unsigned                 MAX_FAIL    = 3,
   parameter int unsigned                 LOCKOUT_CYC = 16,
   parameter int unsigned                 TIMEOUT_CYC = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              sym_valid,
   input  logic [SYM_W-1:0]                  sym,
   input  logic                              relock,
   input  logic                              prog_valid,
   input  logic [CODE_LEN*SYM_W-1:0]         code_in,
   output logic                              unlocked,
   output logic                              alarm,
   output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

   localparam int unsigned CW   = CODE_LEN * SYM_W;
   localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
   localparam int unsigned IW   = $clog2(CODE_LEN + 1);
   localparam int unsigned TMAX = (LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   lock_state_e    state_q, state_n;
   logic [CW-1:0]  code_q, code_n;
   logic [IW-1:0]  idx_q, idx_n;
   logic           match_q, match_n;
   logic [FW-1:0]  fail_n, fail_inc;
   logic           sym_ok, hit, last;
   logic           tmr_load, tmr_expired;
   logic [TW-1:0]  tmr_value;

   // idx is 0 and match is 1 whenever LOCKED, so one compare path serves both states.
   assign sym_ok   = (MAX_SYM_W'(sym) == sym_at(MAX_CODE_W'(code_q), 32'(idx_q), SYM_W));
   assign hit      = match_q & sym_ok;
   assign last     = (idx_q == IW'(CODE_LEN - 1));
   assign fail_inc = fail_cnt + 1'b1;

   always_comb begin
      state_n   = state_q;
      code_n    = code_q;
      idx_n     = idx_q;
      match_n   = match_q;
      fail_n    = fail_cnt;
      tmr_load  = 1'b0;
      tmr_value = '0;

      case (state_q)
         LOCKED, ENTRY: begin
            if (sym_valid) begin
               if (last) begin
                  if (hit) begin
                     state_n = OPEN;
                     fail_n  = '0;
                  end else begin
                     fail_n  = fail_inc;
                     state_n = (fail_inc == FW'(MAX_FAIL)) ? LOCKOUT : LOCKED;
                  end
               end else begin
                  state_n = ENTRY;
                  idx_n   = idx_q + 1'b1;
                  match_n = hit;
               end
            end else if (state_q == ENTRY && tmr_expired) begin
               state_n = LOCKED;
            end
         end
         OPEN: begin
            if (prog_valid) code_n = code_in;
            if (relock) state_n = LOCKED;
         end
         LOCKOUT: begin
            if (tmr_expired) begin
               state_n = LOCKED;
               fail_n  = '0;
            end
         end
         default: state_n = LOCKED;
      endcase

      if (state_n != ENTRY) begin
         idx_n   = '0;
         match_n = 1'b1;
      end

      // Reload on every state change and on each accepted entry symbol.
      tmr_load = (state_n != state_q) || (state_q == ENTRY && sym_valid);
      case (state_n)
         ENTRY:   tmr_value = TW'(TIMEOUT_CYC);
         LOCKOUT: tmr_value = TW'(LOCKOUT_CYC);
         default: tmr_value = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= LOCKED;
         code_q   <= RESET_CODE;
         idx_q    <= '0;
         match_q  <= 1'b1;
         fail_cnt <= '0;
         unlocked <= 1'b0;
         alarm    <= 1'b0;
      end else begin
         state_q  <= state_n;
         code_q   <= code_n;
         idx_q    <= idx_n;
         match_q  <= match_n;
         fail_cnt <= fail_n;
         unlocked <= (state_n == OPEN);
         alarm    <= (state_n == LOCKOUT);
      end
   end

   lock_timer #(
      .W(TW)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .value   (tmr_value),
      .expired (tmr_expired)
   );

endmodule
